// File: rtl/audio_pkg.sv
// Shared definitions for the audio request arbiter and the sequence player:
// sound codes, arbiter FSM states and mask/code helper types.
package audio_pkg;

    localparam int unsigned NUM_SOUNDS = 7;

    typedef logic [NUM_SOUNDS-1:0] snd_mask_t;
    typedef logic [2:0]            snd_code_t;

    localparam snd_code_t SND_PLAY0     = 3'd0;
    localparam snd_code_t SND_PLAY1     = 3'd1;
    localparam snd_code_t SND_LEVEL_INC = 3'd2;
    localparam snd_code_t SND_WORLD_INC = 3'd3;
    localparam snd_code_t SND_LIFE_DECR = 3'd4;
    localparam snd_code_t SND_WIN       = 3'd5;
    localparam snd_code_t SND_LOSE      = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } arb_state_e;

    function automatic snd_mask_t code_to_mask(input snd_code_t code);
        return snd_mask_t'(1) << code;
    endfunction

endpackage

// File: rtl/audio_request_arbiter_if.sv
// Request/grant bus between game logic, the arbiter and the sequence player.
// master = game logic + player side, slave = arbiter.
interface audio_request_arbiter_if;
    import audio_pkg::*;

    snd_mask_t req;
    logic      seq_end;
    logic      clear_err;
    snd_code_t audio_select;
    logic      seq_enable;
    logic      seq_reset;
    logic      busy;
    snd_mask_t pending;
    logic      timeout_err;

    modport master (
        output req,
        output seq_end,
        output clear_err,
        input  audio_select,
        input  seq_enable,
        input  seq_reset,
        input  busy,
        input  pending,
        input  timeout_err
    );

    modport slave (
        input  req,
        input  seq_end,
        input  clear_err,
        output audio_select,
        output seq_enable,
        output seq_reset,
        output busy,
        output pending,
        output timeout_err
    );

endinterface

// File: rtl/audio_request_arbiter_prio_enc.sv
// Combinational highest-set-bit encoder over the pending sound mask.
// Highest code wins; valid_o flags a non-empty mask.
module audio_prio_enc
    import audio_pkg::*;
(
    input  snd_mask_t req_i,
    output snd_code_t code_o,
    output logic      valid_o
);

    always_comb begin
        code_o  = '0;
        valid_o = 1'b0;
        // Ascending scan: the last set bit seen is the highest one.
        for (int unsigned i = 0; i < NUM_SOUNDS; i++) begin
            if (req_i[i[2:0]]) begin
                code_o  = snd_code_t'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/audio_request_arbiter.sv
// Arbitrates one-cycle sound requests onto the single sequence player:
// latch, grant highest code, wait for seq_end (with watchdog), then a silent gap.
module audio_request_arbiter
    import audio_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 400_000_000,
    parameter int unsigned GAP_CYCLES     = 1_000_000
) (
    input logic                    clk,
    input logic                    reset,
    audio_request_arbiter_if.slave bus
);

    localparam logic [31:0] TIMEOUT_LAST = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] GAP_LAST     = (GAP_CYCLES == 0)     ? 32'd0 : 32'(GAP_CYCLES - 1);

    arb_state_e  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] cnt_inc;
    snd_mask_t   pending_q, pending_d;
    snd_code_t   sel_q, sel_d;
    logic        seq_enable_q, seq_enable_d;
    logic        seq_reset_q, seq_reset_d;
    logic        busy_q, busy_d;
    logic        timeout_err_q, timeout_err_d;

    snd_code_t   win_code;
    logic        win_valid;
    logic        grant;
    logic        expire;

    audio_prio_enc u_prio_enc (
        .req_i   (pending_q),
        .code_o  (win_code),
        .valid_o (win_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            pending_q     <= '0;
            sel_q         <= '0;
            seq_enable_q  <= 1'b0;
            seq_reset_q   <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pending_q     <= pending_d;
            sel_q         <= sel_d;
            seq_enable_q  <= seq_enable_d;
            seq_reset_q   <= seq_reset_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        expire  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    state_d = ST_ISSUE;
                    grant   = 1'b1;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.seq_end) begin
                    state_d = ST_GAP;
                end else if (cnt_q >= TIMEOUT_LAST) begin
                    state_d = ST_GAP;
                    expire  = 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q >= GAP_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Shared counter: zero during ISSUE so a WAIT cycle's count equals cycles since ISSUE;
    // restarted at zero on entry to GAP. Saturates instead of wrapping.
    always_comb begin
        cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE:  cnt_d = '0;
            ST_ISSUE: cnt_d = cnt_inc;
            ST_WAIT:  cnt_d = (state_d == ST_GAP) ? '0 : cnt_inc;
            ST_GAP:   cnt_d = cnt_inc;
            default:  cnt_d = '0;
        endcase
    end

    always_comb begin
        pending_d     = (pending_q & ~(grant ? code_to_mask(win_code) : snd_mask_t'('0))) | bus.req;
        sel_d         = grant ? win_code : sel_q;
        seq_enable_d  = (state_d == ST_ISSUE);
        seq_reset_d   = expire;
        busy_d        = (state_d != ST_IDLE);
        timeout_err_d = expire | (timeout_err_q & ~bus.clear_err);
    end

    assign bus.audio_select = sel_q;
    assign bus.seq_enable   = seq_enable_q;
    assign bus.seq_reset    = seq_reset_q;
    assign bus.busy         = busy_q;
    assign bus.pending      = pending_q;
    assign bus.timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_audio_request_arbiter.sv
// Self-checking bench for audio_request_arbiter (TIMEOUT_CYCLES=50, GAP_CYCLES=4);
// expected grant order and timing are derived from the priority and gap/timeout rules.
module tb_audio_request_arbiter;

    localparam int TO = 50;
    localparam int GP = 4;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;
    logic [6:0] exp_pend;
    logic       exp_err;

    audio_request_arbiter_if bus ();

    audio_request_arbiter #(
        .TIMEOUT_CYCLES (TO),
        .GAP_CYCLES     (GP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
        cyc++;
        bus.req       = '0;
        bus.seq_end   = 1'b0;
        bus.clear_err = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int highest(input logic [6:0] m);
        int h;
        h = -1;
        for (int i = 6; i >= 0; i--) begin
            if (m[i] && h < 0) h = i;
        end
        return h;
    endfunction

    // Expects a grant of 'code' at cycle 'issue'; seq_end arrives d cycles after ISSUE
    // (d > TO-1 means the watchdog fires instead). 'extra' is re-requested three times
    // during service; 'keep' is requested again in the grant cycle.
    task automatic serve(input int code, input int issue, input int d,
                         input logic [6:0] extra, input logic [6:0] keep, output int endc);
        int n;
        bit tmo;
        logic [6:0] cm;
        cm = '0;
        cm[code] = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.seq_enable !== 1'b1 && n < 300);
        chk("issue_cycle", cyc, issue);
        chk("issue_sel", bus.audio_select, code);
        chk("issue_busy", bus.busy, 1);
        exp_pend = (exp_pend & ~cm) | keep;
        chk("issue_pending", bus.pending, exp_pend);
        tmo  = (d > TO - 1);
        endc = tmo ? issue + TO - 1 : issue + d;
        while (cyc < endc + GP + 1) begin
            tick();
            if (cyc == issue + d) bus.seq_end = 1'b1;
            if (extra != 0 && (cyc == issue + 2 || cyc == issue + 4 || cyc == issue + 6))
                bus.req = extra;
            if (tmo && cyc == issue + TO) exp_err = 1'b1;
            chk("seq_enable_low", bus.seq_enable, 0);
            chk("seq_reset", bus.seq_reset, (tmo && cyc == issue + TO));
            chk("busy", bus.busy, (cyc <= endc + GP));
            chk("timeout_err", bus.timeout_err, exp_err);
            if (cyc <= endc) chk("sel_held", bus.audio_select, code);
        end
        exp_pend |= extra;
        chk("end_pending", bus.pending, exp_pend);
    endtask

    initial begin
        int k;
        int e;
        int nxt;
        logic [6:0] m;

        cyc = 0;
        checks = 0;
        errors = 0;
        exp_pend = '0;
        exp_err = 1'b0;
        reset = 1'b1;
        bus.req = '0;
        bus.seq_end = 1'b0;
        bus.clear_err = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_sel", bus.audio_select, 0);
        chk("rst_enable", bus.seq_enable, 0);
        chk("rst_seq_reset", bus.seq_reset, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_pending", bus.pending, 0);
        chk("rst_err", bus.timeout_err, 0);
        reset = 1'b0;

        // Single request: seq_enable two cycles later
        k = cyc;
        bus.req = 7'b0000100;
        exp_pend = 7'b0000100;
        tick();
        chk("t1_pending", bus.pending, 7'b0000100);
        chk("t1_enable_early", bus.seq_enable, 0);
        serve(2, k + 2, 10, '0, '0, e);

        // Three simultaneous requests: served 6, 4, 2
        tick();
        k = cyc;
        bus.req = 7'b1010100;
        exp_pend = 7'b1010100;
        nxt = k + 2;
        while (exp_pend != 0) begin
            serve(highest(exp_pend), nxt, int'($urandom_range(1, 40)), '0, '0, e);
            nxt = e + GP + 2;
        end

        // Watchdog timeout, next grant after gap, then clear_err
        tick();
        k = cyc;
        bus.req = 7'b0100010;
        exp_pend = 7'b0100010;
        serve(5, k + 2, 70, '0, '0, e);
        chk("t3_err_set", bus.timeout_err, 1);
        serve(1, e + GP + 2, 5, '0, '0, e);
        tick();
        bus.clear_err = 1'b1;
        tick();
        exp_err = 1'b0;
        chk("t3_err_clear", bus.timeout_err, 0);

        // Repeated requests for the code in service merge into one
        tick();
        k = cyc;
        bus.req = 7'b0010000;
        exp_pend = 7'b0010000;
        serve(4, k + 2, 20, 7'b0010000, '0, e);
        serve(4, e + GP + 2, 6, '0, '0, e);
        chk("t4_drained", bus.pending, 0);
        repeat (3) tick();
        chk("t4_idle_enable", bus.seq_enable, 0);
        chk("t4_idle_busy", bus.busy, 0);

        // Request in the grant cycle of the same bit stays pending
        tick();
        k = cyc;
        bus.req = 7'b0001000;
        exp_pend = 7'b0001000;
        tick();
        bus.req = 7'b0001000;
        chk("t4_grant_cycle_pend", bus.pending, 7'b0001000);
        serve(3, k + 2, 8, '0, 7'b0001000, e);
        serve(3, e + GP + 2, 4, '0, '0, e);

        // seq_end on the expiry cycle wins; seq_end in IDLE is ignored
        tick();
        k = cyc;
        bus.req = 7'b1000000;
        exp_pend = 7'b1000000;
        serve(6, k + 2, TO - 1, '0, '0, e);
        chk("t5_no_err", bus.timeout_err, 0);
        tick();
        bus.seq_end = 1'b1;
        tick();
        tick();
        chk("t5_idle_busy", bus.busy, 0);
        chk("t5_idle_enable", bus.seq_enable, 0);
        chk("t5_idle_seq_reset", bus.seq_reset, 0);
        chk("t5_idle_pending", bus.pending, 0);

        // Randomized bursts with random seq_end delays (some time out)
        for (int r = 0; r < 4; r++) begin
            tick();
            k = cyc;
            m = 7'($urandom_range(1, 127));
            bus.req = m;
            exp_pend = m;
            nxt = k + 2;
            while (exp_pend != 0) begin
                serve(highest(exp_pend), nxt, int'($urandom_range(1, 60)), '0, '0, e);
                nxt = e + GP + 2;
            end
            if (exp_err) begin
                tick();
                bus.clear_err = 1'b1;
                tick();
                exp_err = 1'b0;
                chk("rnd_err_clear", bus.timeout_err, 0);
            end
        end

        // Reset during WAIT aborts; a later request is served normally
        tick();
        k = cyc;
        bus.req = 7'b1000000;
        tick();
        tick();
        chk("t6_enable", bus.seq_enable, 1);
        repeat (5) tick();
        reset = 1'b1;
        bus.req = 7'b0100000;
        tick();
        chk("t6_sel", bus.audio_select, 0);
        chk("t6_enable_rst", bus.seq_enable, 0);
        chk("t6_seq_reset", bus.seq_reset, 0);
        chk("t6_busy", bus.busy, 0);
        chk("t6_pending", bus.pending, 0);
        chk("t6_err", bus.timeout_err, 0);
        reset = 1'b0;
        k = cyc;
        bus.req = 7'b0000001;
        exp_pend = 7'b0000001;
        exp_err = 1'b0;
        serve(0, k + 2, 3, '0, '0, e);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
